instruction_fetch: RTL and testbench

Instruction fetch unit that produces the 32-bit instruction stream consumed by the `decoder`. It keeps the program counter and issues word reads to instruction memory with a req/ack handshake. It buffers returned words in a 2-entry FIFO and presents them to the decoder with a valid/ready handshake. It takes jump redirects from execute, flushes wrong-path words and restarts fetch at the new PC.

---
 rtl/instruction_fetch_pkg.sv | 21 ++
 rtl/instruction_fetch_fifo.sv | 85 ++++++++
 rtl/instruction_fetch.sv | 132 +++++++++++++
 tb/tb_instruction_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch unit and its decoder-facing consumers:
// instruction width, operation field position, fetch FSM states and default reset PC.
package instruction_fetch_pkg;

    localparam int INSTR_W          = 32'd32;
    localparam int OP_MSB           = 32'd15;
    localparam int OP_LSB           = 32'd14;
    localparam int DEFAULT_RESET_PC = 32'd0;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    // Operation field as the decoder sees it.
    function automatic logic [OP_MSB-OP_LSB:0] instr_op(input logic [INSTR_W-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Two-entry FIFO of {pc, word} entries between instruction memory and the decoder.
// The head entry lives in a dedicated register so the decoder outputs are register-driven.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = 32'd16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  push_pc,
    input  logic [INSTR_W-1:0] push_word,
    output logic [ADDR_W-1:0]  head_pc,
    output logic [INSTR_W-1:0] head_word,
    output logic               full,
    output logic               empty,
    output logic [1:0]         count
);

    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [ENTRY_W-1:0] head_r, tail_r, head_s, tail_s, din_s;
    logic [1:0]         count_r, count_s;
    logic               pop_s, push_s;

    assign din_s  = {push_pc, push_word};
    assign pop_s  = pop && (count_r != 2'd0);
    assign push_s = push && ((count_r != 2'd2) || pop_s);

    // Next head/tail/count from push, pop and flush; flush wins over everything.
    always_comb begin
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        if (flush) begin
            count_s = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_s = din_s;
                    end else begin
                        tail_s = din_s;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_s  = tail_r;
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_s = din_s;
                    end else begin
                        head_s = tail_r;
                        tail_s = din_s;
                    end
                end
                default: count_s = count_r;
            endcase
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {ENTRY_W{1'b0}};
            tail_r  <= {ENTRY_W{1'b0}};
            count_r <= 2'd0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
        end
    end

    assign head_pc   = head_r[ENTRY_W-1:INSTR_W];
    assign head_word = head_r[INSTR_W-1:0];
    assign full      = (count_r == 2'd2);
    assign empty     = (count_r == 2'd0);
    assign count     = count_r;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: program counter, one-outstanding-request memory handshake,
// jump redirect with stale-request tracking, and a 2-entry buffer toward the decoder.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32'd16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_e      state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s, pending_pc_r, pending_pc_s;
    logic              stale_r, stale_s, req_r;
    logic              push_s, pop_s, ack_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [1:0]        fifo_count_s, count_next_s;

    assign ack_s  = (state_r == ST_FETCH) && imem_ack;
    assign pop_s  = !fifo_empty_s && instr_ready;
    // A redirect in the ack cycle or an earlier one makes the returning word wrong-path.
    assign push_s = ack_s && !stale_r && !redirect && (!fifo_full_s || pop_s);

    // Occupancy after this cycle decides whether another request fits.
    always_comb begin
        if (redirect) begin
            count_next_s = 2'd0;
        end else begin
            count_next_s = fifo_count_s + {1'b0, push_s} - {1'b0, pop_s};
        end
    end

    // Next-state, next-PC and stale/pending tracking.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        stale_s      = stale_r;
        pending_pc_s = pending_pc_r;
        case (state_r)
            ST_FETCH: begin
                if (imem_ack) begin
                    stale_s = 1'b0;
                    if (redirect) begin
                        pc_s = redirect_pc;
                    end else if (stale_r) begin
                        pc_s = pending_pc_r;
                    end else begin
                        pc_s = pc_r + PC_ONE;
                    end
                    if (count_next_s < 2'd2) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end else if (redirect) begin
                    stale_s      = 1'b1;
                    pending_pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_HOLD, ST_RESET: begin
                if (redirect) begin
                    pc_s = redirect_pc;
                end else begin
                    pc_s = pc_r;
                end
                if (count_next_s < 2'd2) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_RESET;
                stale_s = 1'b0;
            end
        endcase
    end

    // Control registers; the request strobe is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_RESET;
            pc_r         <= RESET_PC;
            pending_pc_r <= RESET_PC;
            stale_r      <= 1'b0;
            req_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            pending_pc_r <= pending_pc_s;
            stale_r      <= stale_s;
            req_r        <= (state_s == ST_FETCH);
        end
    end

    fetch_fifo #(
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (redirect),
        .push_pc   (pc_r),
        .push_word (imem_rdata),
        .head_pc   (instr_pc),
        .head_word (instruction),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr_valid = !fifo_empty_s;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: streaming, backpressure, redirects, PC wrap, reset abort.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk, rst;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        ack_mode;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] word_of(input logic [15:0] a);
        return {~a, a};
    endfunction

    // Memory model: ack in the request cycle when enabled, data derived from the address.
    assign imem_ack   = ack_mode ? imem_req : 1'b0;
    assign imem_rdata = word_of(imem_addr);

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instruction); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", instr_pc); end
    endtask

    task automatic test_stream();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin
                errors++; $display("FAIL stream_req: k=%0d req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 16'(k));
            end
            checks++;
            if (k == 0) begin
                if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_valid0: got %b expected 0", instr_valid); end
            end else if (instr_valid !== 1'b1 || instr_pc !== 16'(k-1) || instruction !== word_of(16'(k-1))) begin
                errors++; $display("FAIL stream_out: k=%0d valid=%b pc=%h instr=%h expected pc=%h", k, instr_valid, instr_pc, instruction, 16'(k-1));
            end
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0003) begin
            errors++; $display("FAIL stream_last: valid=%b pc=%h expected pc=0003", instr_valid, instr_pc);
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 16'h0003 || instruction !== word_of(16'h0003)) begin
                errors++; $display("FAIL hold: i=%0d req=%b valid=%b pc=%h expected req=0 valid=1 pc=0003", i, imem_req, instr_valid, instr_pc);
            end
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 16'(4 + i) || instruction !== word_of(16'(4 + i))) begin
                errors++; $display("FAIL resume: i=%0d valid=%b pc=%h expected pc=%h", i, instr_valid, instr_pc, 16'(4 + i));
            end
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin
            errors++; $display("FAIL resume_addr: req=%b addr=%h expected 0008", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        instr_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rh_hold: req=%b expected 0", imem_req); end
        redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
            errors++; $display("FAIL rh_issue: valid=%b req=%b addr=%h expected 0/1/0200", instr_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0200) begin
            errors++; $display("FAIL rh_first: valid=%b pc=%h expected 1/0200", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
    endtask

    task automatic test_redirect_pending();
        redirect = 1'b1; redirect_pc = 16'h0005;
        tick();
        ack_mode = 1'b0;
        redirect_pc = 16'h0030;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rp_wait1: req=%b addr=%h valid=%b expected 1/0005/0", imem_req, imem_addr, instr_valid);
        end
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 16'h0005 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rp_wait2: addr=%h valid=%b expected 0005/0", imem_addr, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin
            errors++; $display("FAIL rp_wait3: req=%b addr=%h expected 1/0005", imem_req, imem_addr);
        end
        ack_mode = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
            errors++; $display("FAIL rp_drop: valid=%b req=%b addr=%h expected 0/1/0040", instr_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0040 || instruction !== word_of(16'h0040)) begin
            errors++; $display("FAIL rp_target: valid=%b pc=%h instr=%h expected pc=0040", instr_valid, instr_pc, instruction);
        end
    endtask

    task automatic test_redirect_ack();
        redirect = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
            errors++; $display("FAIL ra_issue: valid=%b req=%b addr=%h expected 0/1/0100", instr_valid, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin
            errors++; $display("FAIL ra_first: valid=%b pc=%h expected 1/0100", instr_valid, instr_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        checks++; if (imem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_top: addr=%h expected ffff", imem_addr); end
        tick();
        checks++;
        if (imem_addr !== 16'h0000 || instr_pc !== 16'hFFFF || instruction !== word_of(16'hFFFF)) begin
            errors++; $display("FAIL wrap_next: addr=%h pc=%h expected addr=0000 pc=ffff", imem_addr, instr_pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
            errors++; $display("FAIL wrap_pc: valid=%b pc=%h expected 1/0000", instr_valid, instr_pc);
        end
    endtask

    task automatic test_reset_midop();
        instr_ready = 1'b0;
        ack_mode    = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
            errors++; $display("FAIL mr_setup: valid=%b req=%b addr=%h expected 1/1/0001", instr_valid, imem_req, imem_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 16'h0000) begin
            errors++; $display("FAIL mr_async: req=%b addr=%h valid=%b instr=%h pc=%h expected all zero", imem_req, imem_addr, instr_valid, instruction, instr_pc);
        end
        ack_mode    = 1'b1;
        instr_ready = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL mr_restart: req=%b addr=%h valid=%b expected 1/0000/0", imem_req, imem_addr, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || imem_addr !== 16'h0001) begin
            errors++; $display("FAIL mr_first: valid=%b pc=%h addr=%h expected 1/0000/0001", instr_valid, instr_pc, imem_addr);
        end
    endtask

    initial begin
        rst         = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        ack_mode    = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_hold();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
